// File: rtl/pbuff_window_reader.sv
`default_nettype none
// ============================================================================
//  Module      : pbuff_window_reader
//  Description : Read-side sequencer for partial_buffer. After each committed
//                line it sweeps the column address, assembles a sliding
//                SLICE x SLICE pixel window from the column slices and streams
//                one window per interior column. Output is suppressed until
//                SLICE lines of the frame are resident.
//  Revision    : 1.0 - initial release
// ============================================================================
module pbuff_window_reader #(
   parameter int HWIDTH = 640,
   parameter int AW     = 10,
   parameter int DW     = 12,
   parameter int SLICE  = 3,
   parameter int LW     = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sof,
   input  logic                     line_rdy,
   output logic [AW-1:0]            raddr,
   input  logic [DW*SLICE-1:0]      rdata,
   output logic                     win_valid,
   output logic [DW*SLICE*SLICE-1:0] win_data,
   output logic [AW-1:0]            win_col,
   output logic [LW-1:0]            win_row,
   output logic                     busy,
   output logic                     overrun
);

   localparam logic [AW-1:0] c_LAST_COL  = AW'(HWIDTH - 1);
   localparam logic [AW-1:0] c_FIRST_WIN = AW'(SLICE - 1);
   localparam logic [AW-1:0] c_CTR_OFS   = AW'(SLICE / 2);
   localparam logic [LW-1:0] c_MIN_LINES = LW'(SLICE);
   localparam logic [LW-1:0] c_ROW_OFS   = LW'(SLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_flush_cnt;
   logic [LW-1:0]         r_line_cnt;
   logic                  r_rd_vld;
   logic [AW-1:0]         r_rd_col;
   // Previously read columns; index SLICE-2 is the most recent one.
   logic [DW*SLICE-1:0]   r_col [SLICE-1];
   logic [LW-1:0]         w_cnt_inc;
   logic [DW*SLICE*SLICE-1:0] w_win;
   logic                  w_win_fire;

   assign busy       = (r_state != S_IDLE);
   assign w_cnt_inc  = (r_line_cnt == {LW{1'b1}}) ? r_line_cnt : r_line_cnt + LW'(1);
   assign w_win_fire = r_rd_vld && (r_rd_col >= c_FIRST_WIN) && (r_line_cnt >= c_MIN_LINES);

   // Window assembly: stored columns on the left, the column arriving this cycle on the right.
   for (genvar r = 0; r < SLICE; r++) begin : g_row
      for (genvar c = 0; c < SLICE; c++) begin : g_col
         if (c == SLICE - 1) begin : g_new
            assign w_win[(r*SLICE+c)*DW +: DW] = rdata[r*DW +: DW];
         end else begin : g_old
            assign w_win[(r*SLICE+c)*DW +: DW] = r_col[c][r*DW +: DW];
         end
      end
   end

   // Sequencer FSM: accept a line, sweep the column address, drain the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_flush_cnt <= 1'b0;
         r_line_cnt  <= '0;
         raddr       <= '0;
         overrun     <= 1'b0;
      end else begin
         if (line_rdy && (r_state != S_IDLE))
            overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (line_rdy) begin
                  // sof in the same cycle clears first, so this line counts as the first.
                  r_line_cnt <= sof ? LW'(1) : w_cnt_inc;
                  raddr      <= '0;
                  r_state    <= S_SCAN;
               end else if (sof) begin
                  r_line_cnt <= '0;
               end
            end
            S_SCAN: begin
               if (raddr == c_LAST_COL) begin
                  r_flush_cnt <= 1'b0;
                  r_state     <= S_FLUSH;
               end else begin
                  raddr <= raddr + AW'(1);
               end
            end
            S_FLUSH: begin
               if (r_flush_cnt) begin
                  raddr   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_flush_cnt <= 1'b1;
               end
            end
            default: begin
               raddr   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Read-return tracking, column shift register and registered window output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_vld  <= 1'b0;
         r_rd_col  <= '0;
         win_valid <= 1'b0;
         win_data  <= '0;
         win_col   <= '0;
         win_row   <= '0;
         for (int i = 0; i < SLICE - 1; i++)
            r_col[i] <= '0;
      end else begin
         r_rd_vld  <= (r_state == S_SCAN);
         r_rd_col  <= raddr;
         win_valid <= w_win_fire;
         if (r_rd_vld) begin
            for (int i = 0; i < SLICE - 2; i++)
               r_col[i] <= r_col[i+1];
            r_col[SLICE-2] <= rdata;
         end
         if (w_win_fire) begin
            win_data <= w_win;
            win_col  <= r_rd_col - c_CTR_OFS;
            win_row  <= r_line_cnt - c_ROW_OFS;
         end
      end
   end

endmodule
`default_nettype wire
